// File: rtl/path_job_sequencer_if.sv
// Job request, CPU memory-port and path-stream signals of path_job_sequencer.
interface path_job_sequencer_if;
  logic        job_valid;
  logic        job_ready;
  logic [7:0]  job_sp;
  logic [7:0]  job_ep;
  logic        cpu_reset;
  logic        Ext_MemWrite;
  logic [31:0] Ext_WriteData;
  logic [31:0] Ext_DataAdr;
  logic        MemWrite;
  logic [31:0] WriteData;
  logic [31:0] DataAdr;
  logic [7:0]  path_pt;
  logic        path_valid;
  logic        path_ready;
  logic        path_last;
  logic        done;
  logic        err_timeout;
  logic        err_ovf;
  logic [2:0]  states;

  // master: the sequencer; slave: job source, CPU memory subsystem and path consumer
  modport master (
    input  job_valid, job_sp, job_ep, MemWrite, WriteData, DataAdr, path_ready,
    output job_ready, cpu_reset, Ext_MemWrite, Ext_WriteData, Ext_DataAdr,
           path_pt, path_valid, path_last, done, err_timeout, err_ovf, states
  );
  modport slave (
    output job_valid, job_sp, job_ep, MemWrite, WriteData, DataAdr, path_ready,
    input  job_ready, cpu_reset, Ext_MemWrite, Ext_WriteData, Ext_DataAdr,
           path_pt, path_valid, path_last, done, err_timeout, err_ovf, states
  );
endinterface

// File: rtl/path_job_sequencer.sv
// Loads start/end points into the soft CPU, releases it and streams the path points it writes.
// Define WDOG_EN to enable the RUN-phase watchdog (TIMEOUT_CYC cycles).
module path_job_sequencer #(
  parameter logic [31:0] PATH_BASE   = 32'h0200_0008,
  parameter logic [31:0] DONE_ADR    = 32'h0200_0048,
  parameter int unsigned MAX_PTS     = 16,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input logic                  adc_sck,
  input logic                  rst_n,
  path_job_sequencer_if.master bus
);
  localparam int unsigned PW = $clog2(MAX_PTS);
  localparam int unsigned CW = PW + 1;
  localparam logic [31:0] SP_ADR   = 32'h0200_0000;
  localparam logic [31:0] EP_ADR   = 32'h0200_0004;
  localparam logic [31:0] PATH_END = PATH_BASE + 32'(4 * MAX_PTS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RST   = 3'd1,
    WR_SP = 3'd2,
    WR_EP = 3'd3,
    RUN   = 3'd4,
    DRAIN = 3'd5,
    ERR   = 3'd6
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    sp_q, ep_q;
  logic [7:0]    mem_q [MAX_PTS];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          cpu_reset_q, ext_we_q, done_q, err_tmo_q, err_ovf_q;
  logic [31:0]   ext_wd_q, ext_adr_q;
  logic          accept_c, in_range_c, push_req_c, done_wr_c, empty_c, full_c;
  logic          pop_c, push_c, flush_c, tmo_c;
  logic          unused_bits;

  assign accept_c   = (state == IDLE) && bus.job_valid;
  assign in_range_c = (bus.DataAdr >= PATH_BASE) && (bus.DataAdr < PATH_END);
  assign push_req_c = (state == RUN) && bus.MemWrite && in_range_c;
  assign done_wr_c  = (state == RUN) && bus.MemWrite && (bus.DataAdr == DONE_ADR);
  assign empty_c    = (cnt_q == '0);
  assign full_c     = (cnt_q == CW'(MAX_PTS));
  assign pop_c      = bus.path_ready && !empty_c;
  assign push_c     = push_req_c && (!full_c || pop_c);
  assign flush_c    = accept_c || (state == ERR);

`ifdef WDOG_EN
  logic [31:0] wd_q;

  // Counts RUN cycles; held at zero outside RUN so it starts clean on entry
  always_ff @(posedge adc_sck or negedge rst_n) begin
    if (!rst_n)             wd_q <= '0;
    else if (state != RUN)  wd_q <= '0;
    else                    wd_q <= wd_q + 32'd1;
  end

  assign tmo_c       = (wd_q == 32'(TIMEOUT_CYC - 1));
  assign unused_bits = ^bus.WriteData[31:8];
`else
  assign tmo_c       = 1'b0;
  assign unused_bits = ^{bus.WriteData[31:8], 32'(TIMEOUT_CYC)};
`endif

  always_ff @(posedge adc_sck or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A done word in the watchdog's last cycle takes priority over the timeout
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.job_valid) state_nxt = RST;
      RST:     state_nxt = WR_SP;
      WR_SP:   state_nxt = WR_EP;
      WR_EP:   state_nxt = RUN;
      RUN: begin
        if (done_wr_c)  state_nxt = DRAIN;
        else if (tmo_c) state_nxt = ERR;
      end
      DRAIN:   if (empty_c) state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs are derived from the state being entered
  always_ff @(posedge adc_sck or negedge rst_n) begin
    if (!rst_n) begin
      sp_q        <= '0;
      ep_q        <= '0;
      cpu_reset_q <= 1'b1;
      ext_we_q    <= 1'b0;
      ext_wd_q    <= '0;
      ext_adr_q   <= '0;
      done_q      <= 1'b0;
      err_tmo_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      if (accept_c) begin
        sp_q <= bus.job_sp;
        ep_q <= bus.job_ep;
      end
      cpu_reset_q <= (state_nxt != RUN);
      ext_we_q    <= (state_nxt == WR_SP) || (state_nxt == WR_EP);
      ext_adr_q   <= (state_nxt == WR_SP) ? SP_ADR :
                     (state_nxt == WR_EP) ? EP_ADR : 32'h0;
      ext_wd_q    <= (state_nxt == WR_SP) ? {24'h0, sp_q} :
                     (state_nxt == WR_EP) ? {24'h0, ep_q} : 32'h0;
      done_q      <= (state == DRAIN) && empty_c;
      if (accept_c)                                err_tmo_q <= 1'b0;
      else if ((state == RUN) && tmo_c && !done_wr_c) err_tmo_q <= 1'b1;
      if (accept_c)                                err_ovf_q <= 1'b0;
      else if (push_req_c && full_c && !pop_c)     err_ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge adc_sck or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_c) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push_c && !pop_c)      cnt_q <= cnt_q + CW'(1);
      else if (pop_c && !push_c) cnt_q <= cnt_q - CW'(1);
    end
  end

  // Storage needs no reset; only entries below the count are ever presented
  always_ff @(posedge adc_sck) begin
    if (push_c) mem_q[wr_ptr_q] <= bus.WriteData[7:0];
  end

  assign bus.job_ready     = (state == IDLE);
  assign bus.cpu_reset     = cpu_reset_q;
  assign bus.Ext_MemWrite  = ext_we_q;
  assign bus.Ext_WriteData = ext_wd_q;
  assign bus.Ext_DataAdr   = ext_adr_q;
  assign bus.path_valid    = !empty_c;
  assign bus.path_pt       = mem_q[rd_ptr_q];
  assign bus.path_last     = !empty_c && (state == DRAIN) && (cnt_q == CW'(1));
  assign bus.done          = done_q;
  assign bus.err_timeout   = err_tmo_q;
  assign bus.err_ovf       = err_ovf_q;
  assign bus.states        = state;
endmodule

// File: tb/tb_path_job_sequencer.sv
// Bench for path_job_sequencer: directed and random jobs against a queue-based path model.
module tb_path_job_sequencer;
  localparam logic [31:0] PATH_BASE = 32'h0200_0008;
  localparam logic [31:0] DONE_ADR  = 32'h0200_0048;
  localparam int unsigned MAX_PTS   = 16;
  localparam int unsigned TMO       = 50;

  logic adc_sck;
  logic rst_n;
  path_job_sequencer_if bus();

  path_job_sequencer #(
    .PATH_BASE(PATH_BASE), .DONE_ADR(DONE_ADR), .MAX_PTS(MAX_PTS), .TIMEOUT_CYC(TMO)
  ) dut (
    .adc_sck(adc_sck), .rst_n(rst_n), .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] q[$];
  bit m_run, m_drain, m_done, m_ovf, m_tmo;

  initial begin
    adc_sck = 1'b0;
    forever #5 adc_sck = ~adc_sck;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no end, expected finish");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_path(input logic [31:0] a);
    return (a >= PATH_BASE) && (a < PATH_BASE + 32'(4 * MAX_PTS));
  endfunction

  // One clock: check outputs, drive the bus for the next edge, advance the model
  task automatic cycle(input bit mw, input logic [31:0] adr, input logic [31:0] wd, input bit rdy);
    bit pop;
    chk("path_valid", bus.path_valid, 32'(q.size() != 0));
    if (q.size() != 0) chk("path_pt", bus.path_pt, q[0]);
    chk("path_last", bus.path_last, 32'(m_drain && q.size() == 1));
    chk("done", bus.done, m_done);
    chk("err_ovf", bus.err_ovf, m_ovf);
    chk("err_timeout", bus.err_timeout, m_tmo);
    chk("cpu_reset", bus.cpu_reset, !m_run);
    chk("states", bus.states, m_run ? 32'd4 : (m_drain ? 32'd5 : 32'd0));
    bus.MemWrite   = mw;
    bus.DataAdr    = adr;
    bus.WriteData  = wd;
    bus.path_ready = rdy;
    m_done = m_drain && (q.size() == 0);
    pop = rdy && (q.size() != 0);
    if (pop) void'(q.pop_front());
    if (m_run && mw && in_path(adr)) begin
      if (q.size() < MAX_PTS) q.push_back(wd[7:0]);
      else m_ovf = 1'b1;
    end
    if (m_run && mw && adr == DONE_ADR) begin
      m_run   = 1'b0;
      m_drain = 1'b1;
    end else if (m_done) begin
      m_drain = 1'b0;
    end
    @(negedge adc_sck);
  endtask

  task automatic start_job(input logic [7:0] sp, input logic [7:0] ep);
    chk("job_ready_idle", bus.job_ready, 1'b1);
    bus.job_valid  = 1'b1;
    bus.job_sp     = sp;
    bus.job_ep     = ep;
    bus.path_ready = 1'b0;
    bus.MemWrite   = 1'b0;
    @(negedge adc_sck);
    bus.job_valid = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_tmo = 1'b0;
    chk("rst_state", bus.states, 3'd1);
    chk("rst_job_ready", bus.job_ready, 1'b0);
    chk("rst_cpu_reset", bus.cpu_reset, 1'b1);
    chk("rst_ext_we", bus.Ext_MemWrite, 1'b0);
    chk("rst_err_ovf", bus.err_ovf, 1'b0);
    chk("rst_err_timeout", bus.err_timeout, 1'b0);
    @(negedge adc_sck);
    chk("sp_state", bus.states, 3'd2);
    chk("sp_we", bus.Ext_MemWrite, 1'b1);
    chk("sp_adr", bus.Ext_DataAdr, 32'h0200_0000);
    chk("sp_data", bus.Ext_WriteData, {24'h0, sp});
    chk("sp_cpu_reset", bus.cpu_reset, 1'b1);
    @(negedge adc_sck);
    chk("ep_state", bus.states, 3'd3);
    chk("ep_we", bus.Ext_MemWrite, 1'b1);
    chk("ep_adr", bus.Ext_DataAdr, 32'h0200_0004);
    chk("ep_data", bus.Ext_WriteData, {24'h0, ep});
    @(negedge adc_sck);
    m_run  = 1'b1;
    m_done = 1'b0;
    chk("run_we", bus.Ext_MemWrite, 1'b0);
    chk("run_adr", bus.Ext_DataAdr, 32'h0);
    chk("run_data", bus.Ext_WriteData, 32'h0);
  endtask

  // Done word, then drain with hold cycles of backpressure followed by pops
  task automatic finish_job(input int hold, input bit rnd);
    int guard = 0;
    bit r;
    cycle(1'b1, DONE_ADR, 32'h1, 1'b0);
    while ((m_drain || m_done) && guard < 200) begin
      r = (guard < hold) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      cycle(1'b0, 32'h0, 32'h0, r);
      guard++;
    end
    chk("drain_bound", 32'(guard < 200), 32'd1);
    chk("done_one_cycle", bus.done, 1'b0);
    chk("end_state", bus.states, 3'd0);
    chk("end_cpu_reset", bus.cpu_reset, 1'b1);
  endtask

  initial begin
    logic [31:0] a;
    int n;
    rst_n = 1'b0;
    bus.job_valid = 1'b0; bus.job_sp = '0; bus.job_ep = '0;
    bus.MemWrite = 1'b0; bus.WriteData = '0; bus.DataAdr = '0; bus.path_ready = 1'b0;
    {m_run, m_drain, m_done, m_ovf, m_tmo} = '0;
    repeat (3) @(negedge adc_sck);
    chk("reset_state", bus.states, 3'd0);
    chk("reset_job_ready", bus.job_ready, 1'b1);
    chk("reset_cpu_reset", bus.cpu_reset, 1'b1);
    chk("reset_ext_we", bus.Ext_MemWrite, 1'b0);
    chk("reset_ext_data", bus.Ext_WriteData, 32'h0);
    chk("reset_ext_adr", bus.Ext_DataAdr, 32'h0);
    chk("reset_path_valid", bus.path_valid, 1'b0);
    chk("reset_path_last", bus.path_last, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_err_timeout", bus.err_timeout, 1'b0);
    chk("reset_err_ovf", bus.err_ovf, 1'b0);
    rst_n = 1'b1;
    @(negedge adc_sck);

    // Normal job; a job request held during RUN must be ignored
    start_job(8'h05, 8'h1A);
    bus.job_valid = 1'b1; bus.job_sp = 8'hFF; bus.job_ep = 8'hEE;
    cycle(1'b1, PATH_BASE, 32'h0000_0005, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0);
    cycle(1'b1, PATH_BASE + 32'd4, 32'hABCD_0009, 1'b0);
    cycle(1'b1, PATH_BASE + 32'd8, 32'h0000_001A, 1'b0);
    bus.job_valid = 1'b0;
    finish_job(0, 1'b0);

    // Backpressure: three entries held, done withheld until the last pop
    start_job(8'h11, 8'h22);
    cycle(1'b1, PATH_BASE, 32'h21, 1'b0);
    cycle(1'b1, PATH_BASE + 32'd4, 32'h22, 1'b0);
    cycle(1'b1, PATH_BASE + 32'd8, 32'h23, 1'b0);
    finish_job(6, 1'b0);

    // Empty job: done two edges after the done word
    start_job(8'h03, 8'h04);
    finish_job(0, 1'b0);

    // Out-of-range writes plus the last in-range word
    start_job(8'h30, 8'h31);
    cycle(1'b1, 32'h0200_0100, 32'h77, 1'b0);
    cycle(1'b1, 32'h0200_0004, 32'h66, 1'b0);
    cycle(1'b1, 32'h0200_0044, 32'h55, 1'b0);
    finish_job(0, 1'b0);

    // Overflow: 17th point dropped, then a write into a full FIFO with a pop is kept
    start_job(8'h40, 8'h41);
    for (int i = 0; i < 17; i++) cycle(1'b1, PATH_BASE + 32'(4 * (i % 16)), $urandom, 1'b0);
    cycle(1'b1, PATH_BASE, 32'hA5, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0);
    finish_job(0, 1'b0);

    // Random jobs
    for (int j = 0; j < 8; j++) begin
      start_job(8'($urandom), 8'($urandom));
      n = $urandom_range(0, 30);
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 3))
          0, 1:    a = PATH_BASE + 32'(4 * $urandom_range(0, 15));
          2:       a = $urandom;
          default: a = PATH_BASE - 32'(4 * $urandom_range(1, 2));
        endcase
        if (a == DONE_ADR) a = a + 32'd4;
        cycle(1'($urandom_range(0, 2) != 0), a, $urandom, 1'($urandom_range(0, 1)));
      end
      finish_job($urandom_range(0, 3), 1'b1);
    end

    // Reset asserted during WR_EP
    bus.job_valid = 1'b1; bus.job_sp = 8'h61; bus.job_ep = 8'h62;
    @(negedge adc_sck);
    bus.job_valid = 1'b0;
    repeat (2) @(negedge adc_sck);
    chk("midrst_pre_state", bus.states, 3'd3);
    chk("midrst_pre_we", bus.Ext_MemWrite, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_we", bus.Ext_MemWrite, 1'b0);
    chk("midrst_cpu_reset", bus.cpu_reset, 1'b1);
    chk("midrst_adr", bus.Ext_DataAdr, 32'h0);
    chk("midrst_state", bus.states, 3'd0);
    @(negedge adc_sck);
    rst_n = 1'b1;
    q.delete();
    {m_run, m_drain, m_done, m_ovf, m_tmo} = '0;
    @(negedge adc_sck);
    chk("midrst_job_ready", bus.job_ready, 1'b1);
    chk("midrst_cpu_reset_after", bus.cpu_reset, 1'b1);
    start_job(8'h71, 8'h72);
    cycle(1'b1, PATH_BASE + 32'd12, 32'h9C, 1'b1);
    finish_job(1, 1'b0);

`ifdef WDOG_EN
    // Watchdog: ERR after TMO RUN cycles, FIFO flushed, flag sticky until next accept
    start_job(8'h07, 8'h08);
    cycle(1'b1, PATH_BASE, 32'h31, 1'b0);
    cycle(1'b1, PATH_BASE + 32'd4, 32'h32, 1'b0);
    for (int k = 2; k < TMO; k++) cycle(1'b0, 32'h0, 32'h0, 1'b0);
    chk("wdog_err_state", bus.states, 3'd6);
    chk("wdog_err_flag", bus.err_timeout, 1'b1);
    chk("wdog_cpu_reset", bus.cpu_reset, 1'b1);
    @(negedge adc_sck);
    chk("wdog_idle_state", bus.states, 3'd0);
    chk("wdog_idle_flag", bus.err_timeout, 1'b1);
    chk("wdog_flushed", bus.path_valid, 1'b0);
    m_run = 1'b0;
    q.delete();
    m_tmo = 1'b1;
    // Done word on the last watchdog cycle wins
    start_job(8'h09, 8'h0A);
    for (int k = 0; k < TMO - 1; k++) cycle(1'b0, 32'h0, 32'h0, 1'b0);
    finish_job(0, 1'b0);
    chk("wdog_tie_no_err", bus.err_timeout, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/path_job_sequencer.md
# path_job_sequencer

Sequences one path-planning job on the soft CPU. It parks the CPU in reset, writes the start and end points into CPU data memory through the external write port, then releases the CPU. While the CPU runs, the block snoops its data-bus writes and captures the path points it emits into an output FIFO. It finishes when the CPU writes the done word, or raises an error on watchdog expiry. It sits between the job source (host/UART front end) and the CPU memory subsystem.

## Interface
- PATH_BASE, 32'h02000008, first CPU address of the path-point array
- DONE_ADR, 32'h02000048, address of the CPU's done word
- MAX_PTS, 16, path FIFO depth and path-array length in words (power of two)
- TIMEOUT_CYC, 1000000, watchdog limit in RUN (only with WDOG_EN)
- adc_sck  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- job_valid  in  1  job request
- job_sp / job_ep  in  8 each  start / end point node ids
- job_ready  out  1  high exactly in IDLE
- cpu_reset  out  1  active-high CPU reset
- Ext_MemWrite  out  1  external memory write strobe
- Ext_WriteData / Ext_DataAdr  out  32 each  external write data / address
- MemWrite  in  1  CPU write strobe (snooped)
- WriteData / DataAdr  in  32 each  CPU write data / address (snooped)
- path_pt  out  8  FIFO head point
- path_valid  out  1  FIFO non-empty
- path_ready  in  1  consumer pop
- path_last  out  1  head is final point of the job
- done  out  1  one-cycle job-complete pulse
- err_timeout / err_ovf  out  1 each  sticky errors, cleared on job accept
- states  out  3  current state encoding, for debug

## Operation
- States: IDLE=0, RST=1, WR_SP=2, WR_EP=3, RUN=4, DRAIN=5, ERR=6.
- IDLE: cpu_reset=1, Ext_MemWrite=0. On job_valid && job_ready, latch SP/EP, clear both err flags, flush the FIFO, and go to RST.
- RST: cpu_reset=1 for one cycle, then go to WR_SP.
- WR_SP: Ext_MemWrite=1, Ext_DataAdr=32'h02000000, Ext_WriteData={24'b0,SP}. Then go to WR_EP.
- WR_EP: same as WR_SP with address 32'h02000004 and data EP. Then go to RUN.
- RUN: cpu_reset=0, Ext_MemWrite=0, Ext_DataAdr=0, Ext_WriteData=0. Snoop the CPU bus:
  - Push: if MemWrite && PATH_BASE <= DataAdr < PATH_BASE+4*MAX_PTS, push WriteData[7:0]. Other addresses are ignored.
  - Overflow: a push when the FIFO is full is dropped and sets err_ovf.
  - Done word: MemWrite && DataAdr==DONE_ADR moves to DRAIN. A push and the done word cannot coincide (different addresses).
- DRAIN: cpu_reset=1 and snooping stops. When the FIFO is empty, pulse done for one cycle and go to IDLE.
- ERR: cpu_reset=1 and the FIFO is flushed. Go to IDLE next cycle; err_timeout remains set.
- FIFO:
  - Count width is log2(MAX_PTS)+1. Pointers wrap modulo MAX_PTS.
  - Push and pop in the same cycle leave the count unchanged; a push into a full FIFO with a simultaneous pop is accepted.
  - A pop when empty is ignored.
  - path_pt is valid whenever path_valid=1, and the consumer may pop during RUN.
- path_last = path_valid && state==DRAIN && count==1.
- job_valid outside IDLE is ignored, not queued.

## Timing
- Reset values:
  - state=IDLE, cpu_reset=1, job_ready=1.
  - Ext_MemWrite=0, Ext_WriteData=0, Ext_DataAdr=0.
  - path_valid=0, path_last=0, done=0, both err flags=0, FIFO empty.
- All outputs except job_ready, path_valid, path_pt, path_last and states are registered.
- Accept at edge N gives: RST at N+1, SP write visible N+2, EP write N+3, cpu_reset falls N+4.
- A push captured at edge M gives path_valid=1 from M+1.
- A done-word write at edge D gives state=DRAIN from D+1.
  - If the FIFO is already empty, done is high during D+2.
- rst_n assertion mid-job returns the block to reset values immediately. The CPU is held in reset and no partial write strobe persists.

## Configuration
- WDOG_EN defined:
  - A 32-bit cycle counter clears on entry to RUN and increments each RUN cycle.
  - When it reaches TIMEOUT_CYC-1 with no done word, the next state is ERR and err_timeout is set.
  - A done word in that same cycle wins: the next state is DRAIN, with no error.
- WDOG_EN undefined: no counter. err_timeout is tied 0, ERR is unreachable, and RUN waits indefinitely.

## Test plan
- Normal job:
  - Stimulus: SP=8'h05, EP=8'h1A. CPU writes 5,9,1A to 0x02000008/0C/10, then writes DONE_ADR.
  - Response: Ext writes (0x02000000,5) then (0x02000004,1A); stream 5,9,1A with path_last on 1A; one done pulse; cpu_reset back to 1.
- Backpressure: path_ready=0 throughout RUN.
  - Response: FIFO holds 3 entries and done is withheld until the last pop.
- Overflow: CPU writes MAX_PTS+1 points with no pops.
  - Response: err_ovf=1; the first 16 points are retained; the 17th is dropped.
- Out-of-range write: CPU writes 0x02000100 and 0x02000004.
  - Response: no push.
- Reset mid-job: assert rst_n low during WR_EP.
  - Response: Ext_MemWrite=0 and cpu_reset=1 immediately; job_ready=1 after release.
- Watchdog (WDOG_EN, TIMEOUT_CYC=50): no done word is written.
  - Response: ERR reached after 50 RUN cycles; err_timeout=1; IDLE next cycle; flag clears on the next accept.
